// File: rtl/maze_pkg.sv
// Shared constants for the DFS maze generator: direction codes, read-port bit
// positions, FSM state encoding and the LFSR reload value.
package maze_pkg;

   localparam logic [1:0] DIR_E = 2'd0;
   localparam logic [1:0] DIR_W = 2'd1;
   localparam logic [1:0] DIR_S = 2'd2;
   localparam logic [1:0] DIR_N = 2'd3;

   localparam int CELL_N = 3;
   localparam int CELL_S = 2;
   localparam int CELL_E = 1;
   localparam int CELL_W = 0;

   localparam logic [15:0] LFSR_INIT = 16'hACE1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_STEP,
      ST_POP,
      ST_DONE
   } maze_state_t;

endpackage

// File: rtl/maze_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), shifting right; the two low
// bits drive the direction rotation of the maze carver.
module maze_lfsr
   import maze_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic        load,
   input  logic [15:0] seed,
   output logic [1:0]  rnd
);

   logic [15:0] state;

   // An all-zero seed would lock the register up, so it falls back to the reset value.
   always_ff @(posedge clk) begin
      if (reset)
         state <= LFSR_INIT;
      else if (load)
         state <= (seed == '0) ? LFSR_INIT : seed;
      else if (en)
         state <= {state[0] ^ state[2] ^ state[3] ^ state[5], state[15:1]};
   end

   assign rnd = state[1:0];

endmodule

// File: rtl/maze_dfs_generator.sv
// Depth-first perfect-maze carver over a WIDTH x HEIGHT grid with a registered
// random-access cell read port. Optional MAZE_GEN_SEED_EN adds a seed port.
module maze_dfs_generator
   import maze_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int HEIGHT  = 16,
   parameter int START_X = 0,
   parameter int START_Y = 0,
   localparam int XW = $clog2(WIDTH),
   localparam int YW = $clog2(HEIGHT),
   localparam int AW = $clog2(WIDTH*HEIGHT)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   input  logic [XW-1:0] rd_x,
   input  logic [YW-1:0] rd_y,
   output logic [3:0]    rd_cell
`ifdef MAZE_GEN_SEED_EN
   ,
   input  logic [15:0]   seed
`endif
);

   localparam int NCELL = WIDTH * HEIGHT;
   localparam logic [AW-1:0] START_IDX = AW'(START_Y * WIDTH + START_X);
   localparam logic [AW:0]   SP_ONE    = (AW+1)'(1);

   maze_state_t   state;
   logic [NCELL-1:0] visited;
   logic [NCELL-1:0] open_e;
   logic [NCELL-1:0] open_s;
   logic [AW:0]   sp;
   logic [AW-1:0] cur_idx;
   logic [XW-1:0] cur_x;
   logic [YW-1:0] cur_y;

   logic [AW-1:0] stack_mem [NCELL];
   logic [AW-1:0] stack_q;

   logic [1:0]    rnd;
   logic          lfsr_load;
   logic [15:0]   lfsr_seed;

`ifdef MAZE_GEN_SEED_EN
   assign lfsr_load = (state == ST_CLEAR);
   assign lfsr_seed = seed;
`else
   assign lfsr_load = 1'b0;
   assign lfsr_seed = LFSR_INIT;
`endif

   maze_lfsr u_lfsr (
      .clk   (clk),
      .reset (reset),
      .en    (busy),
      .load  (lfsr_load),
      .seed  (lfsr_seed),
      .rnd   (rnd)
   );

   // Neighbour candidates of the current cell
   logic [AW-1:0] idx_e, idx_w, idx_s, idx_n;
   logic [3:0]    dir_ok;
   logic          found;
   logic [1:0]    sel_dir;
   logic [1:0]    probe;
   logic [AW-1:0] nb_idx;
   logic [XW-1:0] nb_x;
   logic [YW-1:0] nb_y;
   logic          push;

   assign idx_e = cur_idx + AW'(1);
   assign idx_w = cur_idx - AW'(1);
   assign idx_s = cur_idx + AW'(WIDTH);
   assign idx_n = cur_idx - AW'(WIDTH);

   always_comb begin
      dir_ok        = '0;
      dir_ok[DIR_E] = (cur_x != XW'(WIDTH-1))  && !visited[idx_e];
      dir_ok[DIR_W] = (cur_x != '0)            && !visited[idx_w];
      dir_ok[DIR_S] = (cur_y != YW'(HEIGHT-1)) && !visited[idx_s];
      dir_ok[DIR_N] = (cur_y != '0)            && !visited[idx_n];
   end

   // Probe order E,W,S,N rotated by rnd; first usable direction wins
   always_comb begin
      found   = 1'b0;
      sel_dir = DIR_E;
      probe   = '0;
      for (int unsigned k = 0; k < 4; k++) begin
         probe = 2'(k) + rnd;
         if (!found && dir_ok[probe]) begin
            found   = 1'b1;
            sel_dir = probe;
         end
      end
   end

   always_comb begin
      nb_idx = idx_e;
      nb_x   = cur_x;
      nb_y   = cur_y;
      case (sel_dir)
         DIR_E: begin nb_idx = idx_e; nb_x = cur_x + XW'(1); end
         DIR_W: begin nb_idx = idx_w; nb_x = cur_x - XW'(1); end
         DIR_S: begin nb_idx = idx_s; nb_y = cur_y + YW'(1); end
         default: begin nb_idx = idx_n; nb_y = cur_y - YW'(1); end
      endcase
   end

   assign push = (state == ST_STEP) && found;

   // Stack RAM: the read issued during a backtracking STEP is consumed in POP
   always_ff @(posedge clk) begin
      if (push)
         stack_mem[sp[AW-1:0]] <= cur_idx;
      stack_q <= stack_mem[AW'(sp - SP_ONE)];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         visited <= '0;
         open_e  <= '0;
         open_s  <= '0;
         sp      <= '0;
         cur_idx <= '0;
         cur_x   <= '0;
         cur_y   <= '0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state <= ST_CLEAR;
                  busy  <= 1'b1;
                  done  <= 1'b0;
               end
            end
            ST_CLEAR: begin
               visited            <= '0;
               visited[START_IDX] <= 1'b1;
               open_e             <= '0;
               open_s             <= '0;
               sp                 <= '0;
               cur_idx            <= START_IDX;
               cur_x              <= XW'(START_X);
               cur_y              <= YW'(START_Y);
               state              <= ST_STEP;
            end
            ST_STEP: begin
               if (found) begin
                  // West and north passages live in the neighbour's east/south bit
                  case (sel_dir)
                     DIR_E:   open_e[cur_idx] <= 1'b1;
                     DIR_W:   open_e[idx_w]   <= 1'b1;
                     DIR_S:   open_s[cur_idx] <= 1'b1;
                     default: open_s[idx_n]   <= 1'b1;
                  endcase
                  visited[nb_idx] <= 1'b1;
                  sp      <= sp + SP_ONE;
                  cur_idx <= nb_idx;
                  cur_x   <= nb_x;
                  cur_y   <= nb_y;
               end else if (sp == '0) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  sp    <= sp - SP_ONE;
                  state <= ST_POP;
               end
            end
            ST_POP: begin
               cur_idx <= stack_q;
               cur_x   <= XW'(32'(stack_q) % WIDTH);
               cur_y   <= YW'(32'(stack_q) / WIDTH);
               state   <= ST_STEP;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Read port
   logic [AW-1:0] rd_idx;
   logic [3:0]    rd_val;

   always_comb begin
      rd_idx = '0;
      rd_val = '0;
      if (32'(rd_x) < WIDTH && 32'(rd_y) < HEIGHT) begin
         rd_idx         = AW'(32'(rd_y) * WIDTH + 32'(rd_x));
         rd_val[CELL_S] = open_s[rd_idx];
         rd_val[CELL_E] = open_e[rd_idx];
         if (rd_y != '0)
            rd_val[CELL_N] = open_s[rd_idx - AW'(WIDTH)];
         if (rd_x != '0)
            rd_val[CELL_W] = open_e[rd_idx - AW'(1)];
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         rd_cell <= '0;
      else
         rd_cell <= rd_val;
   end

endmodule

// File: tb/tb_maze_dfs_generator.sv
// Scoreboard bench for maze_dfs_generator: a queue/array DFS reference model
// predicts every maze and its generation time; monitors pop and compare.
module tb_maze_dfs_generator;

   localparam int W  = 7;
   localparam int H  = 5;
   localparam int SX = 2;
   localparam int SY = 1;
   localparam int N  = W * H;
   localparam int XW = $clog2(W);
   localparam int YW = $clog2(H);

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          busy;
   logic          done;
   logic [XW-1:0] rd_x;
   logic [YW-1:0] rd_y;
   logic [3:0]    rd_cell;
   logic [15:0]   seed;

   int unsigned errs   = 0;
   int unsigned checks = 0;

   maze_dfs_generator #(
      .WIDTH   (W),
      .HEIGHT  (H),
      .START_X (SX),
      .START_Y (SY)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .rd_x    (rd_x),
      .rd_y    (rd_y),
      .rd_cell (rd_cell)
`ifdef MAZE_GEN_SEED_EN
      ,
      .seed    (seed)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit          m_e [N];
   bit          m_s [N];
   logic [15:0] m_lfsr;

   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      logic [15:0] t;
      t = s >> 1;
      t[15] = s[0] ^ s[2] ^ s[3] ^ s[5];
      return t;
   endfunction

   function automatic void model_reset();
      m_lfsr = 16'hACE1;
      for (int i = 0; i < N; i++) begin
         m_e[i] = 1'b0;
         m_s[i] = 1'b0;
      end
   endfunction

   // Carves one maze from the spec rules; returns busy cycles (CLEAR + STEPs + POPs).
   function automatic int unsigned model_run(input logic [15:0] sd);
      bit vis [N];
      int st [$];
      int cur, cx, cy, nb, r, d, cyc;
      bit found, fin;
      logic [15:0] lo;
      for (int i = 0; i < N; i++) begin
         vis[i] = 1'b0; m_e[i] = 1'b0; m_s[i] = 1'b0;
      end
      cyc = 1;
`ifdef MAZE_GEN_SEED_EN
      m_lfsr = (sd == 16'h0) ? 16'hACE1 : sd;
`else
      lo = sd;
      m_lfsr = lfsr_next(m_lfsr);
`endif
      cur = SY * W + SX;
      vis[cur] = 1'b1;
      fin = 1'b0;
      d = 0;
      nb = 0;
      while (!fin) begin
         lo = m_lfsr;
         r = int'(lo & 16'h3);
         cyc++;
         m_lfsr = lfsr_next(m_lfsr);
         cx = cur % W;
         cy = cur / W;
         found = 1'b0;
         for (int k = 0; k < 4 && !found; k++) begin
            d = (k + r) % 4;
            case (d)
               0:       nb = (cx < W-1) ? cur + 1 : -1;
               1:       nb = (cx > 0)   ? cur - 1 : -1;
               2:       nb = (cy < H-1) ? cur + W : -1;
               default: nb = (cy > 0)   ? cur - W : -1;
            endcase
            if (nb >= 0) found = !vis[nb];
         end
         if (found) begin
            case (d)
               0:       m_e[cur] = 1'b1;
               1:       m_e[nb]  = 1'b1;
               2:       m_s[cur] = 1'b1;
               default: m_s[nb]  = 1'b1;
            endcase
            vis[nb] = 1'b1;
            st.push_back(cur);
            cur = nb;
         end else if (st.size() == 0) begin
            fin = 1'b1;
         end else begin
            cur = st.pop_back();
            cyc++;
            m_lfsr = lfsr_next(m_lfsr);
         end
      end
      return cyc;
   endfunction

   function automatic logic [3:0] exp_cell(input int x, input int y);
      logic [3:0] c;
      int i;
      c = 4'b0000;
      if (x < W && y < H) begin
         i = y * W + x;
         c[2] = m_s[i];
         c[1] = m_e[i];
         c[3] = (y > 0) ? m_s[i-W] : 1'b0;
         c[0] = (x > 0) ? m_e[i-1] : 1'b0;
      end
      return c;
   endfunction

   // ---------------- scoreboards ----------------
   typedef struct {
      int         x;
      int         y;
      logic [3:0] exp;
   } rd_item_t;

   rd_item_t    rdq [$];
   int unsigned lat_q [$];
   bit          rd_req = 1'b0;

   // Read-port monitor: rd_cell is valid one edge after the address is presented
   always @(posedge clk) begin
      if (rd_req) begin
         rd_item_t it;
         #1;
         checks++;
         if (rdq.size() == 0) begin
            errs++;
            $display("FAIL rd_queue_empty got rd_cell=%b with no expectation", rd_cell);
         end else begin
            it = rdq.pop_front();
            if (rd_cell !== it.exp) begin
               errs++;
               $display("FAIL rd_cell(%0d,%0d) got %b expected %b", it.x, it.y, rd_cell, it.exp);
            end
         end
      end
   end

   // Status monitor: busy/done exclusion and start-to-done cycle count
   int unsigned cnt = 0;
   bit          prev_busy = 1'b0;
   bit          prev_done = 1'b0;

   always @(posedge clk) begin
      int unsigned e;
      #1;
      checks++;
      if (busy === 1'b1 && done === 1'b1) begin
         errs++;
         $display("FAIL busy_done_exclusive got busy=%b done=%b expected not both 1", busy, done);
      end
      if (busy === 1'b1)
         cnt = prev_busy ? cnt + 1 : 1;
      if (done === 1'b1 && !prev_done) begin
         checks++;
         if (lat_q.size() == 0) begin
            errs++;
            $display("FAIL unexpected_done got done=1 expected no completion pending");
         end else begin
            e = lat_q.pop_front();
            if (cnt != e) begin
               errs++;
               $display("FAIL gen_cycles got %0d expected %0d", cnt, e);
            end
            checks++;
            if (cnt > 3*N + 2) begin
               errs++;
               $display("FAIL gen_bound got %0d expected <= %0d", cnt, 3*N + 2);
            end
         end
      end
      prev_busy = (busy === 1'b1);
      prev_done = (done === 1'b1);
   end

   // ---------------- stimulus ----------------
   task automatic check1(input string nm, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got %b expected %b", nm, got, exp);
      end
   endtask

   task automatic dump();
      rd_item_t it;
      for (int y = 0; y < (1 << YW); y++) begin
         for (int x = 0; x < (1 << XW); x++) begin
            rd_x = XW'(x);
            rd_y = YW'(y);
            it.x = x;
            it.y = y;
            it.exp = exp_cell(x, y);
            rdq.push_back(it);
            rd_req = 1'b1;
            @(negedge clk);
         end
      end
      rd_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic start_run(input logic [15:0] sd, input bit track);
      if (track)
         lat_q.push_back(model_run(sd));
      seed  = sd;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check1("start_busy", {3'b0, busy}, 4'd1);
      check1("start_done_low", {3'b0, done}, 4'd0);
   endtask

   task automatic wait_done(input bit pulses);
      int unsigned c;
      bit ok;
      c  = 1;
      ok = 1'b0;
      while (!ok && c <= 3*N + 10) begin
         if (done === 1'b1) begin
            ok = 1'b1;
         end else begin
            if (pulses && (c == 5 || c == 20))
               start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            c++;
         end
      end
      if (!ok) begin
         checks++;
         errs++;
         $display("FAIL done_timeout got done=%b expected 1 within %0d cycles", done, 3*N + 10);
      end
   endtask

   logic [15:0] seeds [6];

   initial begin
      seeds[0] = 16'h1234;
      seeds[1] = 16'h1234;
      seeds[2] = 16'h5678;
      seeds[3] = 16'h0000;
      seeds[4] = 16'hACE1;
      seeds[5] = 16'($urandom);

      reset = 1'b1;
      start = 1'b0;
      seed  = 16'h0;
      rd_x  = '0;
      rd_y  = '0;
      @(negedge clk);
      start = 1'b1;                // reset must override a simultaneous start
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
      model_reset();
      check1("reset_busy", {3'b0, busy}, 4'd0);
      check1("reset_done", {3'b0, done}, 4'd0);
      check1("reset_rd_cell", rd_cell, 4'd0);
      dump();

      for (int run = 0; run < 6; run++) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         start_run(seeds[run], 1'b1);
         wait_done(run == 2);
         dump();
      end

      // Abort mid-generation: reset discards the partial maze and reloads the LFSR
      start_run(16'h1234, 1'b0);
      repeat (29) @(negedge clk);
      check1("midrun_busy", {3'b0, busy}, 4'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      check1("abort_busy", {3'b0, busy}, 4'd0);
      check1("abort_done", {3'b0, done}, 4'd0);
      dump();

      start_run(16'h5678, 1'b1);
      wait_done(1'b0);
      dump();

      repeat (4) @(negedge clk);
      checks++;
      if (lat_q.size() != 0 || rdq.size() != 0) begin
         errs++;
         $display("FAIL pending_expectations got %0d/%0d expected 0/0", lat_q.size(), rdq.size());
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/maze_dfs_generator.md
# maze_dfs_generator

Parametrised depth-first maze generator. Carves a perfect maze (spanning tree, no loops) over a WIDTH x HEIGHT cell grid using an explicit stack and an internal LFSR. Exposes a registered random-access cell read port for the VGA renderer and solver. It replaces the fixed 64x64 carver in the maze top level.

## Interface
- WIDTH, 32: cells in x; must be at least 2.
- HEIGHT, 16: cells in y; must be at least 2.
- START_X, 0: start cell x.
- START_Y, 0: start cell y.
- Derived widths:
  - XW = $clog2(WIDTH)
  - YW = $clog2(HEIGHT)
  - AW = $clog2(WIDTH*HEIGHT)
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to generate a new maze.
- busy  out  1  generation in progress.
- done  out  1  maze complete; held until the next accepted start or reset.
- rd_x  in  XW  read cell x.
- rd_y  in  YW  read cell y.
- rd_cell  out  4  {N,S,E,W} open bits of the cell at (rd_x, rd_y); 1 = passage.
- seed  in  16  LFSR seed, present only with MAZE_GEN_SEED_EN.

## Operation
- **Storage (flop vectors):**
  - visited[W*H]
  - open_e[W*H]: passage to x+1.
  - open_s[W*H]: passage to y+1.
  - Cell index = y*WIDTH + x.
- **Stack:** RAM of W*H entries, AW bits each, holding cell indices. sp is AW+1 bits.
- **FSM: IDLE -> CLEAR -> STEP <-> POP -> DONE.**
- **IDLE / DONE:**
  - start=1 moves to CLEAR.
  - start is ignored in CLEAR, STEP and POP.
- **CLEAR (1 cycle):**
  - Clear visited, open_e, open_s and sp.
  - Set visited[start] and cur=start.
  - Go to STEP.
- **STEP:**
  - Take 2-bit r from the LFSR.
  - Probe directions in order E,W,S,N rotated by r (r=0: E,W,S,N; r=1: W,S,N,E; ...).
  - Select the first neighbour that is in bounds and unvisited.
  - If a neighbour is found:
    - Open the shared passage bit (W opens open_e[x-1]; N opens open_s[y-1]).
    - Mark the neighbour visited.
    - Push cur; sp+1.
    - cur=neighbour.
    - Stay in STEP.
  - Else if sp==0: go to DONE.
  - Else: issue stack read at sp-1, set sp-1, go to POP.
- **POP (1 cycle):** cur = stack read data; go to STEP.
- **LFSR:** advances every cycle while busy.
- **Invariants:**
  - The stack never overflows; sp ≤ W*H-1.
  - At DONE, the number of open passage bits is exactly W*H-1 and every cell is visited.
  - Border walls are never opened: no open_e at x=WIDTH-1, no open_s at y=HEIGHT-1.
- **Read port:**
  - rd_cell is registered with 1-cycle latency and is valid in any state.
  - N = open_s[y-1], W = open_e[x-1]. These bits read 0 at the y=0 and x=0 borders.
  - Out-of-range rd_x or rd_y returns 4'b0000.

## Timing
- **Reset values:**
  - busy=0, done=0, rd_cell=0.
  - FSM in IDLE; all grids, sp and cur cleared.
  - LFSR reloaded with 16'hACE1.
- **Reset precedence:** reset mid-generation aborts immediately and discards the partial maze. Reset overrides a simultaneous start.
- **Start latency:** start sampled in cycle T gives busy=1 in T+1, with done=0 in the same cycle.
- **Cycle cost:** each carve takes 1 cycle; each backtrack takes 2 cycles (STEP + POP).
- **Completion bound:** done asserts no later than 3*W*H+2 cycles after start.
- **busy/done relation:** busy and done are never both 1. busy falls in the same cycle done rises.
- **Restart:** start in DONE restarts generation. done drops in the next cycle.

## Configuration
- **MAZE_GEN_SEED_EN defined:**
  - The seed port exists.
  - The LFSR loads seed in CLEAR; a seed of 0 is replaced by 16'hACE1.
  - Identical seeds give identical mazes.
- **MAZE_GEN_SEED_EN undefined:**
  - No seed port.
  - The LFSR free-runs from reset and is not reloaded in CLEAR, so successive mazes differ.

## Structure
- **maze_pkg:**
  - Direction constants DIR_E=0, DIR_W=1, DIR_S=2, DIR_N=3.
  - rd_cell bit positions (N=3, S=2, E=1, W=0).
  - FSM state encoding.
  - LFSR reset constant 16'hACE1.
- **maze_lfsr sub-module:**
  - 16-bit Fibonacci LFSR, taps 16,14,13,11.
  - Ports: clk, reset, en, load, seed, rnd[1:0].

## Test plan
- **2x2, fixed seed:** start -> done within 14 cycles; exactly 3 open passages; all 4 cells reachable from (0,0) by BFS over rd_cell.
- **32x16 default:** start -> done ≤ 1538 cycles; 511 open passages; no border opening; N/S and E/W bits consistent between neighbours.
- **start while busy:**
  - Pulse start at cycles 5 and 20 after the first start.
  - Required: no restart; done timing identical to the single-start run.
- **Reset mid-run:** reset at cycle 50 -> busy=0, done=0 next cycle; rd_cell of every cell reads 0.
- **Read port:**
  - rd_x=WIDTH gives 4'b0000 one cycle later.
  - rd_x=0 gives W=0; rd_y=0 gives N=0.
- **MAZE_GEN_SEED_EN:**
  - seed=16'h1234 twice gives identical rd_cell dumps.
  - seed=16'h5678 gives a different dump.
  - seed=0 behaves as 16'hACE1.
